// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control FSM and mult_div_unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output mult_start, div_start, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  mult_start, div_start, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (shift-add) / divide (restoring) unit producing HI/LO.
// Optional MULTDIV_DIVZERO_EN: divide by zero finishes in one cycle with a div_zero pulse.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum, trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic               last_iter;
    logic               div_trap;

`ifdef MULTDIV_DIVZERO_EN
    logic divzero_q;

    assign div_trap = (bus.b == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divzero_q <= 1'b0;
        end else begin
            divzero_q <= (state_q == StIdle) && !bus.mult_start && bus.div_start && div_trap;
        end
    end

    assign bus.div_zero = divzero_q;
`else
    assign div_trap     = 1'b0;
    assign bus.div_zero = 1'b0;
`endif

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        abs_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
        abs_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        // Shifted partial remainder minus divisor; bit WIDTH set means restore.
        trial     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mcand_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        last_iter = (cnt_q == CntW'(WIDTH - 1));

        unique case (state_q)
            StIdle: begin
                if (bus.mult_start) begin
                    acc_d    = {{WIDTH{1'b0}}, abs_b};
                    mcand_d  = abs_a;
                    neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    is_div_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StMult;
                end else if (bus.div_start && div_trap) begin
                    done_d = 1'b1;
                end else if (bus.div_start) begin
                    acc_d     = {{WIDTH{1'b0}}, abs_a};
                    mcand_d   = abs_b;
                    neg_d     = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    neg_rem_d = bus.a[WIDTH-1];
                    bzero_d   = (bus.b == '0);
                    is_div_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = StDiv;
                end
            end
            StMult: begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end
            end
            StDiv: begin
                if (!trial[WIDTH]) begin
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    // A zero divisor leaves an all-ones quotient that must not be negated.
                    lo_d = (neg_q && !bzero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; expected results are hand-computed.
module tb_mult_div_unit;
    logic clk;
    logic reset;
    int   nchecks;
    int   nerrors;
    int   lat;
    int   bcyc;
    int   dones;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present operands before the start edge, then scramble them after it.
    task automatic start_op(input logic m, input logic d, input logic [31:0] av,
                            input logic [31:0] bv);
        @(negedge clk);
        bus.mult_start = m;
        bus.div_start  = d;
        bus.a          = av;
        bus.b          = bv;
        @(posedge clk);
        #1;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.a          = 32'hdeadbeef;
        bus.b          = 32'h12345678;
    endtask

    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = bus.busy ? 1 : 0;
        for (int i = 1; i <= 40 && l == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) l = i;
            else if (bus.busy) bc++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nchecks        = 0;
        nerrors        = 0;
        reset          = 1'b0;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_divzero", bus.div_zero, 0);
        @(negedge clk);
        reset = 1'b0;

        // 7 * -3 = -21
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
        wait_done(lat, bcyc);
        check("mul_lat", lat, 33);
        check("mul_busy_cycles", bcyc, 33);
        check("mul_busy_at_done", bus.busy, 0);
        check("mul_hi", bus.hi, 32'hFFFFFFFF);
        check("mul_lo", bus.lo, 32'hFFFFFFEB);
        @(posedge clk);
        #1;
        check("mul_done_pulse", bus.done, 0);
        check("mul_hold", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);

        // -7 / 2 = -3 r -1 ; 7 / -2 = -3 r 1
        start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, bcyc);
        check("div1_lat", lat, 33);
        check("div1", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
        start_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE);
        wait_done(lat, bcyc);
        check("div2", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFD);

        start_op(1'b1, 1'b0, 32'h80000000, 32'h80000000);
        wait_done(lat, bcyc);
        check("mul_min_min", {bus.hi, bus.lo}, 64'h40000000_00000000);
        start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bcyc);
        check("div_min_m1", {bus.hi, bus.lo}, 64'h00000000_80000000);

        // 11 / 5 = 2 r 1, then divide by zero
        start_op(1'b0, 1'b1, 32'd11, 32'd5);
        wait_done(lat, bcyc);
        check("div5", {bus.hi, bus.lo}, 64'h00000001_00000002);
        start_op(1'b0, 1'b1, 32'hFFFFFFF7, 32'd0);
`ifdef MULTDIV_DIVZERO_EN
        check("dz_done", bus.done, 1);
        check("dz_flag", bus.div_zero, 1);
        check("dz_busy", bus.busy, 0);
        check("dz_hold", {bus.hi, bus.lo}, 64'h00000001_00000002);
        @(posedge clk);
        #1;
        check("dz_pulse", {bus.done, bus.div_zero}, 0);
`else
        check("dz_flag_e0", bus.div_zero, 0);
        wait_done(lat, bcyc);
        check("dz_lat", lat, 33);
        check("dz_flag", bus.div_zero, 0);
        check("dz_result", {bus.hi, bus.lo}, 64'hFFFFFFF7_FFFFFFFF);
`endif

        // Simultaneous starts: multiply wins; div_start while busy ignored
        start_op(1'b1, 1'b1, 32'd6, 32'd4);
        dones = 0;
        lat   = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin
                @(negedge clk);
                bus.div_start = 1'b1;
                bus.a         = 32'd100;
                bus.b         = 32'd3;
            end
            @(posedge clk);
            #1;
            bus.div_start = 1'b0;
            if (bus.done) begin
                dones++;
                if (lat == 0) lat = i;
            end
        end
        check("both_lat", lat, 33);
        check("both_dones", dones, 1);
        check("both_result", {bus.hi, bus.lo}, 64'h00000000_00000018);
        check("both_idle", bus.busy, 0);

        // Reset at E15 of a multiply
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        for (int i = 1; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) check("busy_hold", {bus.hi, bus.lo}, 64'h00000000_00000018);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
